// File: rtl/mesh_terminal_agent.sv
// rtl/mesh_terminal_agent.sv - mesh edge terminal: FWFT injection FIFO, delivery sink, route checker, counters
module mesh_terminal_agent #(
    parameter int           PCKG_SZ    = 40,
    parameter int           FIFO_DEPTH = 4,
    parameter logic [7:0]   BDCST      = 8'hFF,
    parameter int           ID_ROW     = 0,
    parameter int           ID_COL     = 0,
    parameter int           CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ld_valid,
    input  logic [PCKG_SZ-1:0]            ld_data,
    output logic                          ld_ready,
    output logic [PCKG_SZ-1:0]            data_out_i_in,
    output logic                          pndng_i_in,
    input  logic                          popin,
    input  logic [PCKG_SZ-1:0]            data_out,
    input  logic                          pndng,
    output logic                          pop,
    output logic                          rx_valid,
    output logic [PCKG_SZ-1:0]            rx_data,
    output logic                          rx_err,
    output logic [CNT_W-1:0]              tx_count,
    output logic [CNT_W-1:0]              rx_count,
    output logic [CNT_W-1:0]              err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {S_IDLE, S_POP} sink_state_t;

    logic [PCKG_SZ-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               fifo_empty, do_load, do_pop;

    sink_state_t        state_q, state_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_err_q, rx_err_d;
    logic [PCKG_SZ-1:0] rx_data_q, rx_data_d;
    logic               misrouted;

    logic [CNT_W-1:0]   tx_cnt_q, rx_cnt_q, err_cnt_q;

    assign fifo_empty = (count_q == '0);
    // A full FIFO can still take a load when the mesh pops the head in the same cycle.
    assign ld_ready   = (count_q < CW'(FIFO_DEPTH)) || popin;
    assign do_load    = ld_valid && ld_ready;
    assign do_pop     = popin && !fifo_empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_load) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_load, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uncleared; the head output is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_load) mem_q[wr_ptr_q] <= ld_data;
    end

    assign data_out_i_in = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign pndng_i_in    = !fifo_empty;
    assign fifo_count    = count_q;

    assign misrouted = (data_out[PCKG_SZ-1 -: 8] != BDCST) &&
                       ((data_out[PCKG_SZ-9 -: 4]  != 4'(ID_ROW)) ||
                        (data_out[PCKG_SZ-13 -: 4] != 4'(ID_COL)));

    always_comb begin
        state_d    = state_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;
        case (state_q)
            S_IDLE: begin
                if (pndng) begin
                    state_d    = S_POP;
                    rx_valid_d = 1'b1;
                    rx_data_d  = data_out;
                    rx_err_d   = misrouted;
                end
            end
            S_POP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign pop      = (state_q == S_POP);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_err   = rx_err_q;

    // Counters hold at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (do_pop && tx_cnt_q != '1)                   tx_cnt_q  <= tx_cnt_q + CNT_ONE;
            if (rx_valid_q && rx_cnt_q != '1)               rx_cnt_q  <= rx_cnt_q + CNT_ONE;
            if (rx_valid_q && rx_err_q && err_cnt_q != '1)  err_cnt_q <= err_cnt_q + CNT_ONE;
        end
    end

    assign tx_count  = tx_cnt_q;
    assign rx_count  = rx_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mesh_terminal_agent.sv
// tb/tb_mesh_terminal_agent.sv - directed self-checking bench for mesh_terminal_agent
module tb_mesh_terminal_agent;
    localparam int PCKG_SZ = 40;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               ld_valid;
    logic [PCKG_SZ-1:0] ld_data;
    logic               ld_ready;
    logic [PCKG_SZ-1:0] data_out_i_in;
    logic               pndng_i_in;
    logic               popin;
    logic [PCKG_SZ-1:0] data_out;
    logic               pndng;
    logic               pop;
    logic               rx_valid;
    logic [PCKG_SZ-1:0] rx_data;
    logic               rx_err;
    logic [CNT_W-1:0]   tx_count, rx_count, err_count;
    logic [2:0]         fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    mesh_terminal_agent #(
        .PCKG_SZ(PCKG_SZ), .FIFO_DEPTH(4), .BDCST(8'hFF),
        .ID_ROW(2), .ID_COL(0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
        .data_out(data_out), .pndng(pndng), .pop(pop),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PCKG_SZ-1:0] mk(input logic [7:0] nx, input logic [3:0] r,
                                              input logic [3:0] c, input logic m, input int pl);
        return {nx, r, c, m, 23'(pl)};
    endfunction

    int exp_tx;
    int exp_pay[4];

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; popin = 1'b0;
        data_out = '0; pndng = 1'b0;
        repeat (75) @(posedge clk);
        #1;
        check("rst_pndng_i_in", 64'(pndng_i_in), 64'd0);
        check("rst_pop",        64'(pop),        64'd0);
        check("rst_rx_valid",   64'(rx_valid),   64'd0);
        check("rst_rx_err",     64'(rx_err),     64'd0);
        check("rst_rx_data",    64'(rx_data),    64'd0);
        check("rst_head",       64'(data_out_i_in), 64'd0);
        check("rst_tx_count",   64'(tx_count),   64'd0);
        check("rst_rx_count",   64'(rx_count),   64'd0);
        check("rst_err_count",  64'(err_count),  64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);

        // first load after reset release
        reset = 1'b0;
        step();
        ld_valid = 1'b1; ld_data = mk(8'h00, 4'd2, 4'd0, 1'b1, 1);
        step();
        ld_valid = 1'b0;
        check("load_pndng", 64'(pndng_i_in), 64'd1);
        check("load_head",  64'(data_out_i_in), 64'(mk(8'h00, 4'd2, 4'd0, 1'b1, 1)));
        popin = 1'b1; step(); popin = 1'b0;
        exp_tx = 1;
        check("drain_pndng", 64'(pndng_i_in), 64'd0);

        // fill, overflow drop, ordered drain
        ld_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ld_data = mk(8'h00, 4'd2, 4'd0, 1'b0, i);
            step();
        end
        ld_valid = 1'b0;
        check("full_count",    64'(fifo_count), 64'd4);
        check("full_ld_ready", 64'(ld_ready),   64'd0);
        ld_valid = 1'b1; ld_data = mk(8'h00, 4'd2, 4'd0, 1'b0, 5);
        step();
        ld_valid = 1'b0;
        check("drop_count", 64'(fifo_count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("order_%0d", i), 64'(data_out_i_in), 64'(mk(8'h00, 4'd2, 4'd0, 1'b0, i)));
            popin = 1'b1; step(); popin = 1'b0;
        end
        exp_tx += 4;
        check("empty_pndng", 64'(pndng_i_in), 64'd0);
        check("tx_after_fill", 64'(tx_count), 64'(exp_tx));

        // full FIFO with simultaneous load and pop
        ld_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ld_data = mk(8'h00, 4'd2, 4'd0, 1'b0, i);
            step();
        end
        ld_data = mk(8'h00, 4'd2, 4'd0, 1'b0, 9);
        popin = 1'b1;
        #1;
        check("sim_ld_ready", 64'(ld_ready), 64'd1);
        step();
        ld_valid = 1'b0; popin = 1'b0;
        exp_tx += 1;
        check("sim_count", 64'(fifo_count), 64'd4);
        exp_pay = '{2, 3, 4, 9};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sim_order_%0d", i), 64'(data_out_i_in), 64'(mk(8'h00, 4'd2, 4'd0, 1'b0, exp_pay[i])));
            popin = 1'b1; step(); popin = 1'b0;
        end
        exp_tx += 4;

        // pop on empty FIFO is ignored
        popin = 1'b1; step(); popin = 1'b0;
        check("empty_pop_count", 64'(fifo_count), 64'd0);
        check("empty_pop_tx",    64'(tx_count),   64'(exp_tx));

        // correctly routed stream: pop every second cycle
        pndng = 1'b1; data_out = mk(8'h00, 4'd2, 4'd0, 1'b0, 7);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("route_pop_%0d", i), 64'(pop), 64'((i % 2) == 0));
            if (pop) check($sformatf("route_err_%0d", i), 64'(rx_err), 64'd0);
        end
        pndng = 1'b0;
        check("route_rx_count", 64'(rx_count), 64'd3);
        check("route_rx_data",  64'(rx_data),  64'(mk(8'h00, 4'd2, 4'd0, 1'b0, 7)));

        // misrouted then broadcast to the same address
        pndng = 1'b1; data_out = mk(8'h00, 4'd1, 4'd3, 1'b0, 5);
        step();
        pndng = 1'b0;
        check("mis_valid", 64'(rx_valid), 64'd1);
        check("mis_err",   64'(rx_err),   64'd1);
        step();
        check("mis_err_count", 64'(err_count), 64'd1);
        pndng = 1'b1; data_out = mk(8'hFF, 4'd1, 4'd3, 1'b0, 6);
        step();
        pndng = 1'b0;
        check("bc_valid", 64'(rx_valid), 64'd1);
        check("bc_err",   64'(rx_err),   64'd0);
        step();
        check("bc_err_count", 64'(err_count), 64'd1);
        check("bc_rx_count",  64'(rx_count),  64'd5);

        // asynchronous reset with FIFO partly full
        ld_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ld_data = mk(8'h00, 4'd2, 4'd0, 1'b0, i);
            step();
        end
        ld_valid = 1'b0;
        check("pre_rst_count", 64'(fifo_count), 64'd3);
        #2 reset = 1'b1;
        #1;
        check("async_pndng", 64'(pndng_i_in), 64'd0);
        check("async_count", 64'(fifo_count), 64'd0);
        check("async_head",  64'(data_out_i_in), 64'd0);
        check("async_tx",    64'(tx_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
